// File: rtl/pe_vec_lane_array_pkg.sv
// Shared types and helpers for the vector-lane processing element: mode and FSM encodings
// and the round-half-up arithmetic shift used by every lane.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_MODE_MAC     = 2'b00,
    PE_MODE_MAXPOOL = 2'b01,
    PE_MODE_AVGPOOL = 2'b10,
    PE_MODE_BYPASS  = 2'b11
  } pe_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFinal,
    StEmit
  } pe_state_e;

  localparam int unsigned SHIFT_W = 5;

  // Adds half an LSB of the result before the shift, so ties round towards +inf.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input logic [SHIFT_W-1:0] sh);
    logic signed [63:0] rnd;
    rnd = (sh == '0) ? 64'sd0 : (64'sd1 <<< (sh - SHIFT_W'(1)));
    return (v + rnd) >>> sh;
  endfunction

endpackage

// File: rtl/pe_vec_lane_array_if.sv
// Pixel-stream input and LSU store-port output of the vector-lane PE.
interface pe_vec_lane_array_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 6
);
  logic                    pix_valid_in;
  logic [LANES*WORD_W-1:0] pix_in;
  logic                    pix_ready_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*WORD_W-1:0] out_data;
  logic [ADDR_W-1:0]       out_addr;

  modport master (
    output pix_valid_in, pix_in, out_ready,
    input  pix_ready_out, out_valid, out_data, out_addr
  );

  modport slave (
    input  pix_valid_in, pix_in, out_ready,
    output pix_ready_out, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/pe_vec_lane.sv
// One pixel lane: accumulator with per-mode update, then bias, rounding shift, saturation
// and optional ReLU on the held accumulator.
module pe_vec_lane import pe_pkg::*; #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ACC_W  = 40
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic                     load,
  input  logic                     update,
  input  pe_mode_e                 mode,
  input  logic signed [WORD_W-1:0] pix,
  input  logic signed [WORD_W-1:0] weight,
  input  logic signed [WORD_W-1:0] bias,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     relu,
  output logic signed [WORD_W-1:0] result,
  output logic                     sat
);
  localparam logic signed [63:0] MaxVal = (64'sd1 <<< (WORD_W - 1)) - 64'sd1;
  localparam logic signed [63:0] MinVal = -(64'sd1 <<< (WORD_W - 1));

  logic signed [ACC_W-1:0]    acc, acc_next, pix_ext, prod_ext;
  logic signed [2*WORD_W-1:0] prod;
  logic signed [63:0]         rounded;

  assign prod     = pix * weight;
  assign prod_ext = ACC_W'(prod);
  assign pix_ext  = ACC_W'(pix);

  always_comb begin
    acc_next = acc;
    unique case (mode)
      PE_MODE_MAC:     acc_next = load ? prod_ext : acc + prod_ext;
      PE_MODE_AVGPOOL: acc_next = load ? pix_ext : acc + pix_ext;
      PE_MODE_MAXPOOL: acc_next = (load || (pix_ext > acc)) ? pix_ext : acc;
      PE_MODE_BYPASS:  acc_next = pix_ext;
      default:         acc_next = acc;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load || update) begin
      acc <= acc_next;
    end
  end

  always_comb begin
    rounded = round_shift(64'(acc) + 64'(bias), shift);
    sat     = 1'b0;
    result  = rounded[WORD_W-1:0];
    if (rounded > MaxVal) begin
      result = MaxVal[WORD_W-1:0];
      sat    = 1'b1;
    end else if (rounded < MinVal) begin
      result = MinVal[WORD_W-1:0];
      sat    = 1'b1;
    end
    if (relu && result[WORD_W-1]) begin
      result = '0;
    end
  end
endmodule

// File: rtl/pe_vec_lane_array.sv
// Vector PE: LANES pixel lanes sharing a broadcast weight/bias, with kernel counter, control
// FSM and a valid/ready result port carrying an auto-incrementing LDM address.
module pe_vec_lane_array import pe_pkg::*; #(
  parameter int unsigned  LANES     = 4,
  parameter int unsigned  WORD_W    = 16,
  parameter int unsigned  CNT_W     = 8,
  parameter int unsigned  LDM_DEPTH = 64,
  localparam int unsigned ADDR_W    = $clog2(LDM_DEPTH),
  localparam int unsigned ACC_W     = 2 * WORD_W + CNT_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en_in,
  input  logic                     layer_done_in,
  input  logic [1:0]               mode_in,
  input  logic                     relu_en_in,
  input  logic [SHIFT_W-1:0]       shift_in,
  input  logic [CNT_W-1:0]         kernel_len_in,
  input  logic [ADDR_W-1:0]        wr_base_in,
  input  logic [ADDR_W-1:0]        wr_stride_in,
  input  logic                     weight_valid_in,
  input  logic signed [WORD_W-1:0] weight_in,
  input  logic                     bias_valid_in,
  input  logic signed [WORD_W-1:0] bias_in,
  pe_vec_lane_array_if.slave       bus,
  output logic                     sat_flag_out
);
  pe_state_e               state;
  pe_mode_e                mode_rg, mode_eff;
  logic                    relu_rg;
  logic [SHIFT_W-1:0]      shift_rg;
  logic [CNT_W-1:0]        klen_rg, klen_eff, cnt;
  logic signed [WORD_W-1:0] bias_rg, bias_eff;
  logic                    accept, last, lane_load, lane_update;
  logic [LANES*WORD_W-1:0] lane_res;
  logic [LANES-1:0]        lane_sat;

  assign bus.pix_ready_out = en_in & ((state == StIdle) | (state == StAccum));

  // Configuration is live in IDLE and frozen from the first accepted sample on.
  always_comb begin
    if (state == StIdle) begin
      mode_eff = pe_mode_e'(mode_in);
      klen_eff = (kernel_len_in == '0) ? CNT_W'(1) : kernel_len_in;
    end else begin
      mode_eff = mode_rg;
      klen_eff = klen_rg;
    end
  end

  assign accept = bus.pix_valid_in & bus.pix_ready_out &
                  ((mode_eff != PE_MODE_MAC) | weight_valid_in);
  assign last        = accept & (cnt == klen_eff - CNT_W'(1));
  assign lane_load   = accept & (state == StIdle);
  assign lane_update = accept & (state == StAccum);
  assign bias_eff    = (mode_rg == PE_MODE_MAC) ? bias_rg : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_vec_lane #(
      .WORD_W(WORD_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .CLK   (CLK),
      .RST   (RST),
      .clear (layer_done_in),
      .load  (lane_load),
      .update(lane_update),
      .mode  (mode_eff),
      .pix   (bus.pix_in[i*WORD_W +: WORD_W]),
      .weight(weight_in),
      .bias  (bias_eff),
      .shift (shift_rg),
      .relu  (relu_rg),
      .result(lane_res[i*WORD_W +: WORD_W]),
      .sat   (lane_sat[i])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= StIdle;
      mode_rg       <= PE_MODE_MAC;
      relu_rg       <= 1'b0;
      shift_rg      <= '0;
      klen_rg       <= '0;
      cnt           <= '0;
      bias_rg       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      sat_flag_out  <= 1'b0;
    end else if (layer_done_in) begin
      state         <= StIdle;
      cnt           <= '0;
      bias_rg       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= wr_base_in;
      sat_flag_out  <= 1'b0;
    end else begin
      // A bias arriving during FINAL wins over the clear and is kept for the next result.
      if (bias_valid_in) begin
        bias_rg <= bias_in;
      end else if (state == StFinal) begin
        bias_rg <= '0;
      end
      case (state)
        StIdle, StAccum: begin
          if (accept) begin
            if (state == StIdle) begin
              mode_rg  <= mode_eff;
              klen_rg  <= klen_eff;
              relu_rg  <= relu_en_in;
              shift_rg <= shift_in;
            end
            if (last) begin
              cnt   <= '0;
              state <= StFinal;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= StAccum;
            end
          end
        end
        StFinal: begin
          bus.out_data  <= lane_res;
          bus.out_valid <= 1'b1;
          sat_flag_out  <= sat_flag_out | (|lane_sat);
          state         <= StEmit;
        end
        StEmit: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_addr  <= bus.out_addr + wr_stride_in;
            state         <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule
